// File: rtl/button_event_classifier_if.sv
// Button classifier signal bundle.
//   btn          : debounced button level (1 = pressed), driven by the master
//   press_edge   : one-cycle pulse per 0->1 transition of btn
//   short_press  : one-cycle pulse, short press with no second press
//   long_press   : one-cycle pulse, button held long enough
//   double_press : one-cycle pulse, second press inside the gap window
//   held         : level, high while a long press is still held
//   event_count  : saturating count of short/long/double events
interface button_event_classifier_if;
  logic       btn;
  logic       press_edge;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic [7:0] event_count;

  modport master (
    output btn,
    input  press_edge, short_press, long_press, double_press, held, event_count
  );

  modport slave (
    input  btn,
    output press_edge, short_press, long_press, double_press, held, event_count
  );
endinterface

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures as short, long or double presses.
// Ports:
//   clk : system clock, all logic on posedge
//   rst : asynchronous active-high reset
//   bus : classifier bundle (slave side): btn in; press_edge, short_press,
//         long_press, double_press, held, event_count out (all registered)
module button_event_classifier #(
  parameter int unsigned LONG_CYCLES = 20,
  parameter int unsigned DBL_GAP     = 8,
  parameter int unsigned CW          = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  button_event_classifier_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS1 = 3'd1;
  localparam logic [2:0] S_WAIT2  = 3'd2;
  localparam logic [2:0] S_PRESS2 = 3'd3;
  localparam logic [2:0] S_LONG   = 3'd4;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DBL_GAP - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_prev_q;
  logic          press_edge_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          dbl_q, dbl_d;
  logic          held_q, held_d;
  logic [7:0]    count_q, count_d;
  logic          rise;

  // btn_prev resets to 1 so a button held through reset is not a new press.
  assign rise = bus.btn & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    held_d  = held_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        if (bus.btn) begin
          if (cnt_q == LONG_LAST) begin
            state_d = S_LONG;
            long_d  = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = S_WAIT2;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT2: begin
        if (bus.btn) begin
          state_d = S_PRESS2;
          dbl_d   = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESS2: begin
        if (!bus.btn) begin
          state_d = S_IDLE;
        end
      end
      S_LONG: begin
        if (!bus.btn) begin
          state_d = S_IDLE;
          held_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase

    // At most one classification pulse per cycle, so a single increment suffices.
    if ((short_d | long_d | dbl_d) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      btn_prev_q   <= 1'b1;
      press_edge_q <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      dbl_q        <= 1'b0;
      held_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_prev_q   <= bus.btn;
      press_edge_q <= rise;
      short_q      <= short_d;
      long_q       <= long_d;
      dbl_q        <= dbl_d;
      held_q       <= held_d;
      count_q      <= count_d;
    end
  end

  assign bus.press_edge   = press_edge_q;
  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = dbl_q;
  assign bus.held         = held_q;
  assign bus.event_count  = count_q;

endmodule
